// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I datapath, with a memory request/ready handshake.
// Define MULTICYCLE_JALR_EN to compile in jalr support (JALR_ADR -> JALR_PC -> ALUWB).
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, ILLEGAL
`ifdef MULTICYCLE_JALR_EN
    , JALR_ADR, JALR_PC
`endif
  } state_t;

  state_t     state, next_state;
  logic [2:0] funct_alu;
  logic [2:0] decode_imm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= next_state;
  end

  // Memory states hold until mem_ready; ILLEGAL only leaves through reset.
  always_comb begin
    next_state = state;
    case (state)
      FETCH:    next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state = MEMADR;
          OP_RTYPE:          next_state = EXECR;
          OP_ITYPE:          next_state = EXECI;
          OP_BRANCH:         next_state = BRANCH;
          OP_JAL:            next_state = JAL;
`ifdef MULTICYCLE_JALR_EN
          OP_JALR:           next_state = JALR_ADR;
`endif
          default:           next_state = ILLEGAL;
        endcase
      end
      MEMADR:   next_state = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  next_state = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    next_state = FETCH;
      MEMWRITE: next_state = mem_ready ? FETCH : MEMWRITE;
      EXECR:    next_state = ALUWB;
      EXECI:    next_state = ALUWB;
      ALUWB:    next_state = FETCH;
      BRANCH:   next_state = FETCH;
      JAL:      next_state = ALUWB;
`ifdef MULTICYCLE_JALR_EN
      JALR_ADR: next_state = JALR_PC;
      JALR_PC:  next_state = ALUWB;
`endif
      ILLEGAL:  next_state = ILLEGAL;
      default:  next_state = FETCH;
    endcase
  end

  // Subtract only for R-type with funct7b5; I-type add ignores IR[30].
  always_comb begin
    case (funct3)
      3'b000:  funct_alu = (op[5] & funct7b5) ? 3'b001 : 3'b000;
      3'b010:  funct_alu = 3'b101;
      3'b110:  funct_alu = 3'b011;
      3'b111:  funct_alu = 3'b010;
      default: funct_alu = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:  decode_imm = 3'b001;
      OP_BRANCH: decode_imm = 3'b010;
      OP_JAL:    decode_imm = 3'b011;
      OP_JALR:   decode_imm = 3'b100;
      default:   decode_imm = 3'b000;
    endcase
  end

  // Outputs are forced low while rst_n is held, even though state already reads FETCH.
  always_comb begin
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    ImmSrc     = 3'b000;
    illegal    = 1'b0;
    if (rst_n) begin
      case (state)
        FETCH: begin
          mem_req   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          ImmSrc  = decode_imm;
        end
        MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ImmSrc  = (op == OP_STORE) ? 3'b001 : 3'b000;
        end
        MEMREAD: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
        end
        MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        MEMWRITE: begin
          mem_req  = 1'b1;
          MemWrite = 1'b1;
          AdrSrc   = 1'b1;
        end
        EXECR: begin
          ALUSrcA    = 2'b10;
          ALUControl = funct_alu;
        end
        EXECI: begin
          ALUSrcA    = 2'b10;
          ALUSrcB    = 2'b01;
          ALUControl = funct_alu;
        end
        ALUWB:    RegWrite = 1'b1;
        BRANCH: begin
          ALUSrcA    = 2'b10;
          ALUControl = 3'b001;
          ImmSrc     = 3'b010;
          PCWrite    = Zero ^ funct3[0];
        end
        JAL: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          ImmSrc  = 3'b011;
          PCWrite = 1'b1;
        end
`ifdef MULTICYCLE_JALR_EN
        JALR_ADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ImmSrc  = 3'b100;
        end
        JALR_PC: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          PCWrite = 1'b1;
        end
`endif
        ILLEGAL:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: every cycle's full output vector is compared
// against hand-written per-state expectations.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic       clk, rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, mem_ready;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  logic [18:0] obs;
  int total, bad;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal)
  );

  assign obs = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc, SrcA, SrcB, ALU, Imm, illegal
  function automatic logic [18:0] p(input logic req, mw, adr, irw, pcw, rw,
                                    input logic [1:0] rs, sa, sb,
                                    input logic [2:0] alu, imm, input logic ill);
    return {req, mw, adr, irw, pcw, rw, rs, sa, sb, alu, imm, ill};
  endfunction

  function automatic logic [18:0] dec_e(input logic [2:0] imm);
    return p(0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0);
  endfunction
  function automatic logic [18:0] adr_e(input logic [2:0] imm);
    return p(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, imm, 0);
  endfunction
  function automatic logic [18:0] exr_e(input logic [2:0] alu);
    return p(0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, alu, 3'b000, 0);
  endfunction
  function automatic logic [18:0] exi_e(input logic [2:0] alu);
    return p(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, alu, 3'b000, 0);
  endfunction
  function automatic logic [18:0] br_e(input logic pcw);
    return p(0,0,0,0,pcw,0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0);
  endfunction

  logic [18:0] f_rdy, f_wait, mem_rd, mem_wb, mem_wr, alu_wb, jal_st, jalr_adr, jalr_pc, ill, off;

  task automatic checkOutput(input string tag, input logic [18:0] observed, input logic [18:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %b want %b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3,
                               input logic f7, input logic z, input logic rdy);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z; mem_ready = rdy;
  endtask

  // Check the current state's outputs mid-cycle, then advance one clock.
  task automatic stepCheck(input string tag, input logic [18:0] expected);
    @(negedge clk);
    checkOutput(tag, obs, expected);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    f_rdy    = p(1,0,0,1,1,0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0);
    f_wait   = p(1,0,0,0,0,0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0);
    mem_rd   = p(1,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
    mem_wb   = p(0,0,0,0,0,1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0);
    mem_wr   = p(1,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
    alu_wb   = p(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
    jal_st   = p(0,0,0,0,1,0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b011, 0);
    jalr_adr = p(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b100, 0);
    jalr_pc  = p(0,0,0,0,1,0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0);
    ill      = p(0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1);
    off      = '0;

    rst_n = 1'b0;
    applyStimulus(OP_RTYPE, 3'b000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("reset_hold", obs, off);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] R-type and I-type funct decode");
    stepCheck("add_fetch", f_rdy);
    stepCheck("add_decode", dec_e(3'b000));
    stepCheck("add_exec", exr_e(3'b000));
    stepCheck("add_wb", alu_wb);
    applyStimulus(OP_RTYPE, 3'b000, 1'b1, 1'b0, 1'b1);
    stepCheck("sub_fetch", f_rdy);
    stepCheck("sub_decode", dec_e(3'b000));
    stepCheck("sub_exec", exr_e(3'b001));
    stepCheck("sub_wb", alu_wb);
    applyStimulus(OP_ITYPE, 3'b000, 1'b1, 1'b0, 1'b1);
    stepCheck("addi_fetch", f_rdy);
    stepCheck("addi_decode", dec_e(3'b000));
    stepCheck("addi_exec", exi_e(3'b000));
    stepCheck("addi_wb", alu_wb);
    applyStimulus(OP_RTYPE, 3'b010, 1'b0, 1'b0, 1'b1);
    stepCheck("slt_fetch", f_rdy);
    stepCheck("slt_decode", dec_e(3'b000));
    stepCheck("slt_exec", exr_e(3'b101));
    stepCheck("slt_wb", alu_wb);
    applyStimulus(OP_ITYPE, 3'b110, 1'b0, 1'b0, 1'b1);
    stepCheck("ori_fetch", f_rdy);
    stepCheck("ori_decode", dec_e(3'b000));
    stepCheck("ori_exec", exi_e(3'b011));
    stepCheck("ori_wb", alu_wb);
    applyStimulus(OP_ITYPE, 3'b111, 1'b0, 1'b0, 1'b1);
    stepCheck("andi_fetch", f_rdy);
    stepCheck("andi_decode", dec_e(3'b000));
    stepCheck("andi_exec", exi_e(3'b010));
    stepCheck("andi_wb", alu_wb);
    applyStimulus(OP_RTYPE, 3'b001, 1'b1, 1'b0, 1'b1);
    stepCheck("f3_001_fetch", f_rdy);
    stepCheck("f3_001_decode", dec_e(3'b000));
    stepCheck("f3_001_exec", exr_e(3'b000));
    stepCheck("f3_001_wb", alu_wb);

    $display("[TB] store with fetch and write stalls");
    applyStimulus(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0);
    stepCheck("sw_fetch_stall", f_wait);
    mem_ready = 1'b1;
    stepCheck("sw_fetch", f_rdy);
    stepCheck("sw_decode", dec_e(3'b001));
    stepCheck("sw_adr", adr_e(3'b001));
    mem_ready = 1'b0;
    stepCheck("sw_write_stall", mem_wr);
    mem_ready = 1'b1;
    stepCheck("sw_write", mem_wr);

    $display("[TB] load with two read stalls");
    applyStimulus(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b1);
    stepCheck("lw_fetch", f_rdy);
    stepCheck("lw_decode", dec_e(3'b000));
    stepCheck("lw_adr", adr_e(3'b000));
    mem_ready = 1'b0;
    stepCheck("lw_read_stall1", mem_rd);
    stepCheck("lw_read_stall2", mem_rd);
    mem_ready = 1'b1;
    stepCheck("lw_read", mem_rd);
    stepCheck("lw_wb", mem_wb);

    $display("[TB] branches");
    applyStimulus(OP_BRANCH, 3'b000, 1'b0, 1'b1, 1'b1);
    stepCheck("beq_z1_fetch", f_rdy);
    stepCheck("beq_z1_decode", dec_e(3'b010));
    stepCheck("beq_z1_branch", br_e(1'b1));
    applyStimulus(OP_BRANCH, 3'b001, 1'b0, 1'b1, 1'b1);
    stepCheck("bne_z1_fetch", f_rdy);
    stepCheck("bne_z1_decode", dec_e(3'b010));
    stepCheck("bne_z1_branch", br_e(1'b0));
    applyStimulus(OP_BRANCH, 3'b000, 1'b0, 1'b0, 1'b1);
    stepCheck("beq_z0_fetch", f_rdy);
    stepCheck("beq_z0_decode", dec_e(3'b010));
    stepCheck("beq_z0_branch", br_e(1'b0));

    $display("[TB] jumps");
    applyStimulus(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1);
    stepCheck("jal_fetch", f_rdy);
    stepCheck("jal_decode", dec_e(3'b011));
    stepCheck("jal_pc", jal_st);
    stepCheck("jal_wb", alu_wb);
    applyStimulus(OP_JALR, 3'b000, 1'b0, 1'b0, 1'b1);
    stepCheck("jalr_fetch", f_rdy);
    stepCheck("jalr_decode", dec_e(3'b100));
`ifdef MULTICYCLE_JALR_EN
    stepCheck("jalr_adr", jalr_adr);
    stepCheck("jalr_pc", jalr_pc);
    stepCheck("jalr_wb", alu_wb);
`else
    stepCheck("jalr_illegal1", ill);
    stepCheck("jalr_illegal2", ill);
    rst_n = 1'b0;
    #1;
    checkOutput("jalr_reset", obs, off);
    @(posedge clk); #1;
    rst_n = 1'b1;
`endif

    $display("[TB] illegal opcode and asynchronous reset");
    applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b1);
    stepCheck("ill_fetch", f_rdy);
    stepCheck("ill_decode", dec_e(3'b000));
    stepCheck("ill_state1", ill);
    mem_ready = 1'b0;
    applyStimulus(OP_RTYPE, 3'b000, 1'b0, 1'b1, 1'b0);
    stepCheck("ill_state2", ill);
    mem_ready = 1'b1;
    stepCheck("ill_state3", ill);
    rst_n = 1'b0;
    #1;
    checkOutput("ill_reset_async", obs, off);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b1);
    stepCheck("post_reset_fetch", f_rdy);
    stepCheck("sw2_decode", dec_e(3'b001));
    stepCheck("sw2_adr", adr_e(3'b001));
    mem_ready = 1'b0;
    stepCheck("sw2_write_stall", mem_wr);
    rst_n = 1'b0;
    #1;
    checkOutput("sw2_reset_async", obs, off);
    mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("sw2_reset_hold", obs, off);
    @(posedge clk); #1;
    rst_n = 1'b1;
    stepCheck("sw2_restart_fetch", f_rdy);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style control FSM for the multicycle RV32I datapath. It sequences one instruction over 3–5 states and drives:
- the immediate-extender select (`ImmSrc`: 000 I, 001 S, 010 B, 011 JAL, 100 JALR),
- the ALU and result muxes,
- register-file, IR and PC write enables.

It handshakes with the shared instruction/data memory through a request/ready pair, so memory wait states stall the sequence without losing control state.

## Interface
No parameters.
- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous active-low reset
- `op` in 7: instruction opcode from IR
- `funct3` in 3: IR[14:12]
- `funct7b5` in 1: IR[30]
- `Zero` in 1: ALU zero flag
- `mem_ready` in 1: memory completes current access this cycle
- `mem_req` out 1: memory access requested
- `MemWrite` out 1: store strobe (valid with `mem_req`)
- `AdrSrc` out 1: 0 = PC, 1 = ALUOut drives memory address
- `IRWrite` out 1: latch instruction and OldPC
- `PCWrite` out 1: update PC from Result
- `RegWrite` out 1: register-file write
- `ResultSrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 rs1
- `ALUSrcB` out 2: 00 rs2, 01 ImmExt, 10 constant 4
- `ALUControl` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt
- `ImmSrc` out 3: extender select
- `illegal` out 1: sticky, unsupported opcode decoded

## Operation
States and transitions:
- **FETCH**
  - Signals: `mem_req`, `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, add, `ResultSrc`=10.
  - `IRWrite` and `PCWrite` are asserted only when `mem_ready`=1.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- **DECODE**
  - Signals: `ALUSrcA`=01, `ALUSrcB`=01, add (branch/JAL target into ALUOut).
  - `ImmSrc` by opcode: 0100011 → 001, 1100011 → 010, 1101111 → 011, 1100111 → 100, else 000.
  - Next state by opcode: 0000011/0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR_ADR (macro); any other → ILLEGAL.
- **MEMADR**
  - Signals: `ALUSrcA`=10, `ALUSrcB`=01, add, `ImmSrc` = 000 for loads, 001 for stores.
  - Loads go to MEMREAD; stores go to MEMWRITE.
- **MEMREAD**
  - Signals: `mem_req`, `AdrSrc`=1, `ResultSrc`=00.
  - Holds until `mem_ready`, then goes to MEMWB.
- **MEMWB**: `ResultSrc`=01, `RegWrite`; then FETCH.
- **MEMWRITE**
  - Signals: `mem_req`, `MemWrite`, `AdrSrc`=1, `ResultSrc`=00.
  - Holds until `mem_ready`, then goes to FETCH.
- **EXECR**: `ALUSrcA`=10, `ALUSrcB`=00, funct decode; then ALUWB.
- **EXECI**: `ALUSrcA`=10, `ALUSrcB`=01, `ImmSrc`=000, funct decode; then ALUWB.
- **ALUWB**: `ResultSrc`=00, `RegWrite`; then FETCH.
- **BRANCH**
  - Signals: `ALUSrcA`=10, `ALUSrcB`=00, sub, `ImmSrc`=010, `ResultSrc`=00.
  - `PCWrite` = `Zero` XOR `funct3[0]` (beq/bne).
  - Then FETCH.
- **JAL**
  - Signals: `ALUSrcA`=01, `ALUSrcB`=10, add, `ImmSrc`=011, `ResultSrc`=00, `PCWrite`.
  - Then ALUWB, which writes OldPC+4.
- **ILLEGAL**: all enables 0; `illegal`=1. Absorbing until reset.

Funct decode (EXECR/EXECI):
- `funct3` 000 → add, or sub when `op[5]` & `funct7b5`.
- 010 → slt; 110 → or; 111 → and.
- Any other `funct3` → add.

Every output not listed for a state is 0.

## Timing
- Reset: `rst_n` low forces state to FETCH immediately and gates every output, including `illegal`, to 0.
  - The first fetch request appears in the first cycle after `rst_n` rises.
  - Reset mid-instruction abandons it; no partial write completes after reset.
- Zero-wait cycle counts (`mem_ready` held high):
  - branch 3
  - R-type, I-type, store 4
  - jal 4
  - load 5
  - jalr 5
- Each low cycle of `mem_ready` in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
  - During those stall cycles `mem_req`, `AdrSrc` and `MemWrite` stay stable.
  - During those stall cycles `IRWrite`, `PCWrite` and `RegWrite` stay 0.
- All outputs are combinational from the state register, plus `mem_ready` (FETCH), `Zero`/`funct3` (BRANCH) and `op`/`funct` (DECODE, EXEC). No output depends on `mem_ready` outside the memory states.

## Configuration
- `MULTICYCLE_JALR_EN` defined: jalr support is compiled in.
  - JALR_ADR: `ALUSrcA`=10, `ALUSrcB`=01, `ImmSrc`=100, add; target goes into ALUOut.
  - JALR_PC: `ALUSrcA`=01, `ALUSrcB`=10, add, `ResultSrc`=00, `PCWrite`.
  - Then ALUWB writes OldPC+4.
- `MULTICYCLE_JALR_EN` undefined: both JALR states are absent, and opcode 1100111 goes to ILLEGAL. `ImmSrc`=100 is still emitted in DECODE.

## Test plan
- `add` (op 0110011, funct3 000, `funct7b5` 0), `mem_ready`=1 → states FETCH, DECODE, EXECR, ALUWB; `ALUControl`=000; `RegWrite` exactly 1 cycle, in cycle 4.
- `lw` with `mem_ready` low for 2 cycles in MEMREAD → 7 cycles total; `mem_req`/`AdrSrc`=1 held for 3 cycles; `RegWrite` with `ResultSrc`=01 once.
- `beq`/`bne` with `Zero`=1 → beq: `PCWrite`=1, `ImmSrc`=010 in BRANCH; bne: `PCWrite`=0; both return to FETCH after 3 cycles.
- `jalr` with macro defined → 5 cycles; `ImmSrc`=100 in DECODE and JALR_ADR; `PCWrite` in JALR_PC; `RegWrite` in ALUWB. Without the macro → `illegal`=1 from cycle 3, all enables 0.
- Opcode 0000000 → ILLEGAL and stays there; deassert `rst_n` mid-state → all outputs 0 immediately; after release, FETCH with `mem_req`=1.
